// File: rtl/cfi_pkg.sv
// Shared types and defaults for the CFI violation handler.
// Mirrors the exception record and cause codes used on the commit/controller path.
package cfi_pkg;

  localparam int unsigned XLEN             = 64;
  localparam int unsigned DefPcW           = 64;
  localparam int unsigned DefCntW          = 16;
  localparam int unsigned DefMaxViolations = 4;
  localparam int unsigned DefHoldoffCycles = 8;
  localparam int unsigned DefLedStretch    = 2 ** 20;

  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;
  localparam logic [XLEN-1:0] BREAKPOINT    = 64'd3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StCooldown
  } cfi_state_e;

endpackage

// File: rtl/cfi_pulse_stretcher.sv
// Retriggerable down-counter: pulse_o stays high for Stretch cycles after the
// last trigger_i.
module cfi_pulse_stretcher #(
  parameter int unsigned Stretch = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trigger_i,
  output logic pulse_o
);

  localparam int unsigned CntW = $clog2(Stretch + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger_i) begin
      cnt_d = CntW'(Stretch);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/cfi_violation_handler.sv
// Turns the CFI checker's one-cycle violation pulse into a held, handshaked
// exception request, and keeps violation statistics, hold-off and halt state.
module cfi_violation_handler
  import cfi_pkg::*;
#(
  parameter int unsigned PC_W           = DefPcW,
  parameter int unsigned CNT_W          = DefCntW,
  parameter int unsigned MAX_VIOLATIONS = DefMaxViolations,
  parameter int unsigned HOLDOFF_CYCLES = DefHoldoffCycles,
  parameter int unsigned LED_STRETCH    = DefLedStretch
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             commit_ack_i0,
  input  logic [PC_W-1:0]  commit_pc_i0,
  input  logic             cfi_signal_i,
  input  exception_t       cfi_ex_i,
  input  logic             clear_i,
  input  logic             ex_ack_i,
  output exception_t       exception_o,
  output logic [CNT_W-1:0] violation_cnt_o,
  output logic [PC_W-1:0]  last_pc_o,
  output logic             overrun_o,
  output logic             halt_o,
  output logic             led_o
);

  localparam int unsigned HoldW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_VIOLATIONS);

  cfi_state_e       state_q;
  exception_t       exc_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  last_pc_q;
  logic [HoldW-1:0] hold_q;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             overrun_q, overrun_d;
  logic             halt_q, halt_d;

  // Only the cause of the checker's exception is consumed.
  logic unused_ex;
  assign unused_ex = ^{cfi_ex_i.tval, cfi_ex_i.valid};

  // Tracks the PC of the last committed instruction on port 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else if (commit_ack_i0) begin
      pc_q <= commit_pc_i0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      exc_q     <= '0;
      last_pc_q <= '0;
      hold_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfi_signal_i) begin
            state_q     <= StPending;
            exc_q.valid <= 1'b1;
            exc_q.cause <= cfi_ex_i.cause;
            exc_q.tval  <= XLEN'(pc_q);
            last_pc_q   <= pc_q;
          end
        end
        StPending: begin
          // Ack takes priority over a simultaneous flush.
          if (ex_ack_i) begin
            state_q <= StCooldown;
            exc_q   <= '0;
            hold_q  <= HoldW'(HOLDOFF_CYCLES - 1);
          end else if (flush_i) begin
            state_q <= StIdle;
            exc_q   <= '0;
          end
        end
        StCooldown: begin
          if (hold_q == '0) begin
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    halt_d    = halt_q;
    if (clear_i) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
      halt_d    = 1'b0;
    end else if (cfi_signal_i) begin
      cnt_d = cnt_inc;
      if (state_q == StPending) begin
        overrun_d = 1'b1;
      end
      if ((MAX_VIOLATIONS != 0) && (cnt_inc == MaxCnt)) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      halt_q    <= halt_d;
    end
  end

  cfi_pulse_stretcher #(
    .Stretch(LED_STRETCH)
  ) u_led_stretch (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .trigger_i(cfi_signal_i),
    .pulse_o  (led_o)
  );

  assign exception_o     = exc_q;
  assign violation_cnt_o = cnt_q;
  assign last_pc_o       = last_pc_q;
  assign overrun_o       = overrun_q;
  assign halt_o          = halt_q;

endmodule

// File: tb/tb_cfi_violation_handler.sv
// Randomized and directed checks of cfi_violation_handler against a
// cycle-indexed behavioural model of the violation handling rules.
module tb_cfi_violation_handler;
  import cfi_pkg::*;

  localparam int unsigned PcW     = 64;
  localparam int unsigned CntW    = 6;
  localparam int unsigned MaxV    = 4;
  localparam int unsigned Holdoff = 8;
  localparam int unsigned LedLen  = 6;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic             clk;
  logic             rst_ni;
  logic             flush;
  logic             cack;
  logic [PcW-1:0]   cpc;
  logic             sig;
  exception_t       cfi_ex;
  logic             clr;
  logic             ack;
  exception_t       exc;
  logic [CntW-1:0]  cnt;
  logic [PcW-1:0]   last_pc;
  logic             overrun;
  logic             halt;
  logic             led;

  cfi_violation_handler #(
    .PC_W          (PcW),
    .CNT_W         (CntW),
    .MAX_VIOLATIONS(MaxV),
    .HOLDOFF_CYCLES(Holdoff),
    .LED_STRETCH   (LedLen)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush),
    .commit_ack_i0  (cack),
    .commit_pc_i0   (cpc),
    .cfi_signal_i   (sig),
    .cfi_ex_i       (cfi_ex),
    .clear_i        (clr),
    .ex_ack_i       (ack),
    .exception_o    (exc),
    .violation_cnt_o(cnt),
    .last_pc_o      (last_pc),
    .overrun_o      (overrun),
    .halt_o         (halt),
    .led_o          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time is the index of clock edges since reset.
  longint      t;
  bit          m_pending;
  longint      m_idle_at;   // first edge at which a new violation may be accepted
  logic [63:0] m_cause;
  logic [63:0] m_tval;
  logic [63:0] m_last_pc;
  logic [63:0] m_pc;
  int          m_cnt;
  bit          m_over;
  bit          m_halt;
  longint      m_last_sig;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    m_pending  = 0;
    m_idle_at  = 0;
    m_cause    = '0;
    m_tval     = '0;
    m_last_pc  = '0;
    m_pc       = '0;
    m_cnt      = 0;
    m_over     = 0;
    m_halt     = 0;
    m_last_sig = -1000;
  endtask

  task automatic model_edge();
    if (clr) begin
      m_cnt  = 0;
      m_over = 0;
      m_halt = 0;
    end else if (sig) begin
      if (m_cnt < CntMax) m_cnt++;
      if (m_pending) m_over = 1;
      if (MaxV != 0 && m_cnt == int'(MaxV)) m_halt = 1;
    end
    if (sig) m_last_sig = t;
    if (m_pending) begin
      if (ack) begin
        m_pending = 0;
        m_idle_at = t + Holdoff + 1;
      end else if (flush) begin
        m_pending = 0;
        m_idle_at = t + 1;
      end
    end else if (sig && t >= m_idle_at) begin
      m_pending = 1;
      m_cause   = cfi_ex.cause;
      m_tval    = m_pc;
      m_last_pc = m_pc;
    end
    if (cack) m_pc = cpc;
    t++;
  endtask

  task automatic compare_all();
    bit led_exp;
    led_exp = ((t - 1 - m_last_sig) < LedLen);
    check_val("valid",   64'(exc.valid), 64'(m_pending));
    check_val("cause",   exc.cause, m_pending ? m_cause : 64'd0);
    check_val("tval",    exc.tval,  m_pending ? m_tval  : 64'd0);
    check_val("cnt",     64'(cnt),     64'(m_cnt));
    check_val("last_pc", last_pc,      m_last_pc);
    check_val("overrun", 64'(overrun), 64'(m_over));
    check_val("halt",    64'(halt),    64'(m_halt));
    check_val("led",     64'(led),     64'(led_exp));
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge.
  task automatic step(input logic s, input logic a, input logic f, input logic c,
                      input logic ca, input logic [63:0] pc, input logic [63:0] cause);
    sig = s; ack = a; flush = f; clr = c; cack = ca; cpc = pc;
    cfi_ex = '0;
    cfi_ex.cause = cause;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  task automatic async_reset_check();
    rst_ni = 1'b0;
    sig = 0; ack = 0; flush = 0; clr = 0; cack = 0;
    #1;
    check_val("rst_valid",   64'(exc.valid), 64'd0);
    check_val("rst_exc",     exc.tval | exc.cause, 64'd0);
    check_val("rst_cnt",     64'(cnt), 64'd0);
    check_val("rst_last_pc", last_pc, 64'd0);
    check_val("rst_flags",   64'({overrun, halt, led}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_ni = 1'b0;
    sig = 0; ack = 0; flush = 0; clr = 0; cack = 0; cpc = '0; cfi_ex = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_ni = 1'b1;

    // Basic request, hold and ack.
    step(0, 0, 0, 0, 1, 64'h8000_0010, 64'd0);
    step(1, 0, 0, 0, 0, 64'd0, BREAKPOINT);
    check_val("first_tval", exc.tval, 64'h8000_0010);
    check_val("first_cnt", 64'(cnt), 64'd1);
    idle(3);
    check_val("held_valid", 64'(exc.valid), 64'd1);
    step(0, 1, 0, 0, 0, 64'd0, 64'd0);
    check_val("ack_drop", 64'(exc.valid), 64'd0);

    // Hold-off window: ack at E, violation at E+3 ignored, at E+10 accepted.
    idle(2);
    step(1, 0, 0, 0, 1, 64'h8000_0020, ILLEGAL_INSTR);
    check_val("holdoff_valid", 64'(exc.valid), 64'd0);
    check_val("holdoff_cnt", 64'(cnt), 64'd2);
    idle(6);
    step(1, 0, 0, 0, 0, 64'd0, BREAKPOINT);
    check_val("reaccept", 64'(exc.valid), 64'd1);

    // Overrun while pending; fourth violation halts.
    step(1, 0, 0, 0, 1, 64'h8000_0030, ILLEGAL_INSTR);
    check_val("ovr_flag", 64'(overrun), 64'd1);
    check_val("ovr_tval", exc.tval, 64'h8000_0020);
    check_val("halt4", 64'(halt), 64'd1);

    // Flush drops the request, count unchanged.
    step(0, 0, 1, 0, 0, 64'd0, 64'd0);
    check_val("flush_valid", 64'(exc.valid), 64'd0);
    check_val("flush_cnt", 64'(cnt), 64'd4);

    // Clear wins over a simultaneous violation.
    step(1, 0, 0, 1, 0, 64'd0, BREAKPOINT);
    check_val("clr_cnt", 64'(cnt), 64'd0);
    check_val("clr_halt", 64'(halt), 64'd0);

    // Async reset mid-pending, then normal acceptance.
    idle(Holdoff + 2);
    step(1, 0, 0, 0, 1, 64'h1234, BREAKPOINT);
    async_reset_check();
    step(0, 0, 0, 0, 1, 64'h8000_0040, 64'd0);
    step(1, 0, 0, 0, 0, 64'd0, BREAKPOINT);
    check_val("post_rst_tval", exc.tval, 64'h8000_0040);

    // Saturation.
    for (int i = 0; i < CntMax + 8; i++) step(1, 1, 0, 0, 0, 64'd0, BREAKPOINT);
    check_val("sat_cnt", 64'(cnt), 64'(CntMax));
    idle(LedLen + Holdoff + 2);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 40) == 0,
             $urandom_range(0, 1) == 1, {$urandom, $urandom},
             64'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfi_violation_handler.md
# cfi_violation_handler

Downstream consumer of the commit-stage CFI marker checker. Converts the checker's one-cycle `cfi_signal`/exception pulse into a held, handshaked exception request towards the commit/controller path, with tval set to the violating PC. Also keeps violation statistics, enforces a hold-off window against duplicate reports, and raises a sticky halt after a configurable number of violations.

## Interface
- `PC_W`, 64: PC / tval width.
- `CNT_W`, 16: violation counter width.
- `MAX_VIOLATIONS`, 4: count at which `halt_o` sets (0 disables).
- `HOLDOFF_CYCLES`, 8: suppression window after an exception is taken (≥1).
- `LED_STRETCH`, 2**20: LED pulse length in cycles.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `flush_i` in 1: pipeline flush.
- `commit_ack_i0` in 1: commit port 0 acknowledged this cycle.
- `commit_pc_i0` in PC_W: PC of commit port 0 instruction.
- `cfi_signal_i` in 1: checker violation pulse, registered one cycle after detection.
- `cfi_ex_i` in `exception_t`: checker exception; only `.cause` is used.
- `clear_i` in 1: clears counter, overrun and halt (CSR write).
- `ex_ack_i` in 1: controller accepted `exception_o`.
- `exception_o` out `exception_t`: held exception request.
- `violation_cnt_o` out CNT_W: saturating violation count.
- `last_pc_o` out PC_W: PC of most recent accepted violation.
- `overrun_o` out 1: sticky; violation arrived while PENDING.
- `halt_o` out 1: sticky; count reached MAX_VIOLATIONS.
- `led_o` out 1: stretched violation indicator.

## Operation
- `pc_q` is loaded with `commit_pc_i0` on every cycle with `commit_ack_i0=1`. When `cfi_signal_i` rises, `pc_q` is the violating PC.
- FSM states:
  - IDLE:
    - `cfi_signal_i` → PENDING.
    - Latch `exception_o.cause=cfi_ex_i.cause`, `tval=pc_q`, `last_pc_o=pc_q`.
  - PENDING:
    - `exception_o.valid=1`, with cause and tval stable.
    - `ex_ack_i` → COOLDOWN, loading the hold-off counter with HOLDOFF_CYCLES-1.
    - `flush_i` without `ex_ack_i` → IDLE; the request is dropped.
    - `ex_ack_i` and `flush_i` together: ack wins → COOLDOWN.
  - COOLDOWN:
    - Counter decrements each cycle; at 0 → IDLE.
    - `cfi_signal_i` here raises no exception.
- Counting:
  - Every `cfi_signal_i=1` cycle increments `violation_cnt_o`, in every state.
  - Counter saturates at all-ones.
- `cfi_signal_i` while PENDING:
  - Sets `overrun_o`.
  - tval and `last_pc_o` keep the first violation.
- `halt_o` sets in the cycle the count (post-increment) equals MAX_VIOLATIONS, and stays set.
- `clear_i`:
  - Zeroes count, `overrun_o` and `halt_o`.
  - If `cfi_signal_i` is also 1 that cycle, clear wins and the count becomes 0.
  - Does not affect FSM state.
- `led_o`: high for LED_STRETCH cycles after any `cfi_signal_i`; a retrigger restarts the count.

## Timing
- Reset values: all outputs 0; `exception_o` all fields 0; FSM IDLE.
- `cfi_signal_i` at edge N → `exception_o.valid=1` from N+1. Counter, `last_pc_o` and `led_o` also update at N+1.
- `exception_o.valid` drops one cycle after `ex_ack_i` or `flush_i` is sampled.
- Minimum spacing between two accepted exceptions: 1 (PENDING) + HOLDOFF_CYCLES + 1 cycles.
- Reset mid-PENDING or mid-COOLDOWN: immediate (asynchronous) return to IDLE; valid deasserts without an ack.
- `clear_i` takes effect at the next edge.

## Structure
- Shared package `cfi_pkg`:
  - FSM enum `{IDLE, PENDING, COOLDOWN}`.
  - Default parameter constants.
- `exception_t` and cause values come from the existing `ariane_pkg`/`riscv` packages.
- One sub-module, `cfi_pulse_stretcher`: a retriggerable down-counter used for `led_o`.

## Test plan
- Reset, then `cfi_signal_i` for 1 cycle with `pc_q=0x8000_0010`, cause BREAKPOINT:
  - `exception_o.valid=1` from the next cycle, `tval=0x8000_0010`, count=1.
  - Held until `ex_ack_i`; drops one cycle after the ack.
- HOLDOFF_CYCLES=8:
  - Ack, then `cfi_signal_i` 3 cycles later → no exception, count=2.
  - Signal 10 cycles after the ack → new PENDING.
- Second `cfi_signal_i` while PENDING:
  - `overrun_o=1`; tval still holds the first PC; count=2.
- `flush_i` in PENDING with no ack:
  - valid drops next cycle, FSM IDLE, count unchanged.
- MAX_VIOLATIONS=4:
  - 4th violation → `halt_o=1`.
  - `clear_i` → count=0, `halt_o=0`.
  - Count saturates at 0xFFFF when MAX_VIOLATIONS=0.
- Assert `rst_ni` low asynchronously mid-PENDING:
  - All outputs 0 before the next clock edge.
  - After release, a new signal is accepted normally.
